// File: rtl/dataplane_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dataplane_pkg
//  Brief    : Shared constants, parser state type and checksum helper.
//  Revision : 1.0
// ============================================================================
package dataplane_pkg;

    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
    localparam logic [6:0]  ETH_HDR_LEN  = 7'd14;
    localparam logic [3:0]  IPV4_MIN_IHL = 4'd5;
    localparam logic [3:0]  IPV4_VERSION = 4'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ETH     = 3'd1,
        IP_HDR  = 3'd2,
        PAYLOAD = 3'd3,
        SKIP    = 3'd4
    } ipv4_state_e;

    // Even header offsets carry the high byte of a 16-bit word.
    function automatic logic [15:0] csum_word_part(input logic [7:0] b, input logic odd);
        return odd ? {8'h00, b} : {b, 8'h00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipv4_csum_acc.sv
`default_nettype none
// ============================================================================
//  Module   : ipv4_csum_acc
//  Brief    : Ones'-complement checksum accumulator (clear / add / fold).
//  Revision : 1.0
// ============================================================================
module ipv4_csum_acc #(
    parameter int ADD_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_add_en,
    input  logic [ADD_W-1:0] i_add,
    output logic [15:0]      o_sum_folded
);
    localparam int SUM_W = ((ADD_W > 20) ? ADD_W : 20) + 1;

    logic [19:0]      r_acc;
    logic [SUM_W-1:0] w_sum;
    logic [16:0]      w_fold1;
    logic [15:0]      w_fold2;

    // Partial end-around fold on every update keeps the 20-bit register from overflowing.
    always_comb begin
        w_sum        = SUM_W'(r_acc) + SUM_W'(i_add);
        w_fold1      = {1'b0, w_sum[15:0]} + 17'(w_sum[SUM_W-1:16]);
        w_fold2      = w_fold1[15:0] + {15'd0, w_fold1[16]};
        o_sum_folded = w_fold2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= {3'd0, w_fold1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ipv4_parser.sv
`default_nettype none
// ============================================================================
//  Module   : ipv4_parser
//  Brief    : IPv4 header extraction/validation with 1-cycle stream pass-through.
//  Revision : 1.0
// ============================================================================
module ipv4_parser
    import dataplane_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             tdata_in,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_in,
    input  logic                              data_valid_in,
    input  logic                              last_flag_in,
    output logic [DATA_WIDTH-1:0]             tdata_out,
    output logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_out,
    output logic                              data_valid_out,
    output logic                              last_flag_out,
    output logic                              ipv4_hdr_valid,
    output logic                              ipv4_hdr_err,
    output logic [3:0]                        ip_ihl,
    output logic [15:0]                       ip_total_len,
    output logic [7:0]                        ip_ttl,
    output logic [7:0]                        ip_protocol,
    output logic [31:0]                       ip_src,
    output logic [31:0]                       ip_dst
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(NB + 1);
    localparam int ADD_W = 17 + $clog2(NB);

    ipv4_state_e r_state, w_state_a, w_state_n;
    logic [6:0]  r_off, w_off_a, w_off_n, w_rel;
    logic [15:0] r_ethertype, w_ethertype;
    logic [3:0]  r_ihl, w_ihl;
    logic [15:0] r_total_len, w_total_len;
    logic [7:0]  r_ttl, w_ttl, r_proto, w_proto, w_byte;
    logic [31:0] r_src, w_src, r_dst, w_dst;
    logic [ADD_W-1:0] w_add;
    logic        w_add_en, w_hdr_done, w_err_a, w_clr_a;
    logic        w_err, w_valid_set, w_csum_clr;
    logic [15:0] w_csum;

    logic [DATA_WIDTH-1:0] r_tdata;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_dv, r_last, r_valid, r_err;

    // Byte walk: lanes in order, state transitions may chain within one beat.
    always_comb begin
        w_state_a   = r_state;
        w_off_a     = r_off;
        w_ethertype = r_ethertype;
        w_ihl       = r_ihl;
        w_total_len = r_total_len;
        w_ttl       = r_ttl;
        w_proto     = r_proto;
        w_src       = r_src;
        w_dst       = r_dst;
        w_add       = '0;
        w_add_en    = 1'b0;
        w_hdr_done  = 1'b0;
        w_err_a     = 1'b0;
        w_clr_a     = 1'b0;
        w_byte      = '0;
        w_rel       = '0;
        for (int i = 0; i < NB; i++) begin
            if (data_valid_in && (IDX_W'(i) < idx_in)) begin
                w_byte = tdata_in[i*8 +: 8];
                w_rel  = w_off_a - ETH_HDR_LEN;
                case (w_state_a)
                    IDLE, ETH: begin
                        w_state_a = ETH;
                        if (w_off_a == ETH_HDR_LEN - 7'd2)
                            w_ethertype[15:8] = w_byte;
                        if (w_off_a == ETH_HDR_LEN - 7'd1) begin
                            w_ethertype[7:0] = w_byte;
                            w_state_a = ({w_ethertype[15:8], w_byte} == ETHTYPE_IPV4) ? IP_HDR : SKIP;
                        end
                    end
                    IP_HDR: begin
                        w_add_en = 1'b1;
                        w_add    = w_add + ADD_W'(csum_word_part(w_byte, w_rel[0]));
                        case (w_rel)
                            7'd0: begin
                                if (w_byte[7:4] != IPV4_VERSION || w_byte[3:0] < IPV4_MIN_IHL) begin
                                    w_err_a   = 1'b1;
                                    w_clr_a   = 1'b1;
                                    w_state_a = SKIP;
                                end else begin
                                    w_ihl = w_byte[3:0];
                                end
                            end
                            7'd2:  w_total_len[15:8] = w_byte;
                            7'd3:  w_total_len[7:0]  = w_byte;
                            7'd8:  w_ttl             = w_byte;
                            7'd9:  w_proto           = w_byte;
                            7'd12: w_src[31:24]      = w_byte;
                            7'd13: w_src[23:16]      = w_byte;
                            7'd14: w_src[15:8]       = w_byte;
                            7'd15: w_src[7:0]        = w_byte;
                            7'd16: w_dst[31:24]      = w_byte;
                            7'd17: w_dst[23:16]      = w_byte;
                            7'd18: w_dst[15:8]       = w_byte;
                            7'd19: w_dst[7:0]        = w_byte;
                            default: ;
                        endcase
                        if (w_state_a == IP_HDR && w_rel == {1'b0, w_ihl, 2'b00} - 7'd1) begin
                            w_hdr_done = 1'b1;
                            w_clr_a    = 1'b1;
                            w_state_a  = PAYLOAD;
                        end
                    end
                    default: ;
                endcase
                if (w_off_a != 7'h7F)
                    w_off_a = w_off_a + 7'd1;
            end
        end
    end

    // Completion verdict and end-of-frame handling.
    always_comb begin
        w_state_n   = w_state_a;
        w_off_n     = w_off_a;
        w_err       = w_err_a;
        w_csum_clr  = w_clr_a;
        w_valid_set = 1'b0;
        if (w_hdr_done) begin
            if (w_csum == 16'hFFFF && w_total_len >= {10'd0, w_ihl, 2'b00})
                w_valid_set = 1'b1;
            else
                w_err = 1'b1;
        end
        if (data_valid_in && last_flag_in) begin
            if (w_state_a == IP_HDR) begin
                w_err      = 1'b1;
                w_csum_clr = 1'b1;
            end
            w_state_n = IDLE;
            w_off_n   = '0;
        end
    end

    ipv4_csum_acc #(
        .ADD_W (ADD_W)
    ) u_csum (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_csum_clr),
        .i_add_en     (w_add_en),
        .i_add        (w_add),
        .o_sum_folded (w_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_off       <= '0;
            r_ethertype <= '0;
            r_ihl       <= '0;
            r_total_len <= '0;
            r_ttl       <= '0;
            r_proto     <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_tdata     <= '0;
            r_idx       <= '0;
            r_dv        <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_off       <= w_off_n;
            r_ethertype <= w_ethertype;
            r_ihl       <= w_ihl;
            r_total_len <= w_total_len;
            r_ttl       <= w_ttl;
            r_proto     <= w_proto;
            r_src       <= w_src;
            r_dst       <= w_dst;
            r_err       <= w_err;
            // Hold valid through the delayed last beat so it coincides with last_flag_out.
            if (w_valid_set)
                r_valid <= 1'b1;
            else if (r_dv && r_last)
                r_valid <= 1'b0;
            r_tdata     <= tdata_in;
            r_idx       <= idx_in;
            r_dv        <= data_valid_in;
            r_last      <= last_flag_in;
        end
    end

    assign tdata_out      = r_tdata;
    assign idx_out        = r_idx;
    assign data_valid_out = r_dv;
    assign last_flag_out  = r_last;
    assign ipv4_hdr_valid = r_valid;
    assign ipv4_hdr_err   = r_err;
    assign ip_ihl         = r_ihl;
    assign ip_total_len   = r_total_len;
    assign ip_ttl         = r_ttl;
    assign ip_protocol    = r_proto;
    assign ip_src         = r_src;
    assign ip_dst         = r_dst;

endmodule
`default_nettype wire
